// File: rtl/audio_mem_pkg.sv
// Shared definitions for the audio memory arbiter: requester indices,
// arbiter state encoding and default bus widths.
package audio_mem_pkg;

    localparam int REQ_REC   = 0;
    localparam int REQ_PLAY  = 1;
    localparam int REQ_MIX   = 2;
    localparam int REQ_PITCH = 3;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: scans the valid vector starting at
// 'start' (wrapping) and returns the first set bit as one-hot plus index.
module arb_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/audio_mem_arbiter.sv
// Single-outstanding arbiter for the external audio memory port with a
// watchdog abort. Define AUDIO_ARB_RR_EN for round-robin, else fixed priority.
module audio_mem_arbiter
    import audio_mem_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0]               req_we,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]               req_ready,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic                           mem_ack,
    input  logic [DATA_W-1:0]              mem_rdata
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    arb_state_t       state;
    logic [N_REQ-1:0] owner;
    logic [WD_W-1:0]  wd_cnt;
    logic [PW-1:0]    start_ptr;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    win_idx;
    logic             accept;
    logic             wd_expire;

    arb_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .valid     (req_valid),
        .start     (start_ptr),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    assign accept    = (state == ARB_IDLE) && !i_rst && (|req_valid);
    assign req_ready = {N_REQ{accept}} & grant;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

`ifdef AUDIO_ARB_RR_EN
    logic [PW-1:0] last_win;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_win <= PW'(N_REQ - 1);
        end else if (accept) begin
            last_win <= win_idx;
        end
    end

    assign start_ptr = (last_win == PW'(N_REQ - 1)) ? '0 : last_win + PW'(1);
`else
    assign start_ptr = '0;
`endif

    // An ack arriving on the last watchdog cycle still completes normally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            wd_cnt    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        state     <= ARB_BUSY;
                        owner     <= grant;
                        wd_cnt    <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we[win_idx];
                        mem_addr  <= req_addr[win_idx];
                        mem_wdata <= req_wdata[win_idx];
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack) begin
                        state     <= ARB_IDLE;
                        mem_req   <= 1'b0;
                        rsp_valid <= owner;
                        rsp_rdata <= mem_we ? '0 : mem_rdata;
                    end else if (wd_expire) begin
                        state     <= ARB_IDLE;
                        mem_req   <= 1'b0;
                        rsp_valid <= owner;
                        rsp_err   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Self-checking bench for audio_mem_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_audio_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 16;
    localparam int TO = 8;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_we;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 mem_req;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_ack;
    logic [DW-1:0]        mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: last winner, and what the response cycle must show.
    int            model_last = N - 1;
    logic [N-1:0]  exp_rsp;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [N-1:0]  ready_seen;

    // Per-requester transaction contents for the next applyStimulus call.
    logic [N-1:0]         t_we;
    logic [N-1:0][AW-1:0] t_addr;
    logic [N-1:0][DW-1:0] t_wdata;
    logic [DW-1:0]        t_rdata;

    int w;
    int order_exp [5];

    always #5 i_clk = ~i_clk;

    audio_mem_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner rule: fixed mode takes the lowest valid index; round-robin takes
    // the first valid index after the previous winner, wrapping around.
    function automatic int model_pick(input logic [N-1:0] v);
`ifdef AUDIO_ARB_RR_EN
        for (int n = 1; n <= N; n++)
            if (v[(model_last + n) % N]) return (model_last + n) % N;
`else
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic check_rsp();
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        exp_rsp   = '0;
        exp_err   = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic rand_fields();
        for (int r = 0; r < N; r++) begin
            t_we[r]    = 1'($urandom_range(0, 1));
            t_addr[r]  = AW'($urandom);
            t_wdata[r] = DW'($urandom);
        end
        t_rdata = DW'($urandom);
    endtask

    // One full transaction: accept, k BUSY cycles before ack (k >= TO means
    // never acked), then leaves the bench in the response cycle.
    task automatic applyStimulus(input logic [N-1:0] v, input int k, output int win);
        bit done;
        int j;
        check_rsp();
        req_we    = t_we;
        req_addr  = t_addr;
        req_wdata = t_wdata;
        req_valid = v;
        mem_ack   = 1'b0;
        win = model_pick(v);
        model_last = win;
        #1;
        ready_seen = req_ready;
        checkOutput("req_ready", 32'(req_ready), 32'(1) << win);
        @(negedge i_clk);
        done = 1'b0;
        j = 0;
        while (!done) begin
            req_valid = N'($urandom_range(0, 15));
            req_we    = N'($urandom);
            for (int r = 0; r < N; r++) begin
                req_addr[r]  = AW'($urandom);
                req_wdata[r] = DW'($urandom);
            end
            #1;
            checkOutput("busy_ready", 32'(req_ready), 32'd0);
            checkOutput("mem_req", 32'(mem_req), 32'd1);
            checkOutput("mem_we", 32'(mem_we), 32'(t_we[win]));
            checkOutput("mem_addr", 32'(mem_addr), 32'(t_addr[win]));
            checkOutput("mem_wdata", 32'(mem_wdata), 32'(t_wdata[win]));
            checkOutput("busy_rsp", 32'(rsp_valid), 32'd0);
            if (j == k) begin
                mem_ack   = 1'b1;
                mem_rdata = t_rdata;
                exp_rdata = t_we[win] ? '0 : t_rdata;
                exp_err   = 1'b0;
                done      = 1'b1;
            end else if (j == TO - 1) begin
                exp_rdata = '0;
                exp_err   = 1'b1;
                done      = 1'b1;
            end
            @(negedge i_clk);
            mem_ack   = 1'b0;
            mem_rdata = DW'($urandom);
            j++;
        end
        req_valid = '0;
        exp_rsp   = N'(1 << win);
        #1 checkOutput("mem_req_drop", 32'(mem_req), 32'd0);
    endtask

    task automatic idle_cycle(input bit ack);
        check_rsp();
        req_valid = '0;
        mem_ack   = ack;
        mem_rdata = DW'($urandom);
        #1 checkOutput("idle_ready", 32'(req_ready), 32'd0);
        @(negedge i_clk);
        mem_ack = 1'b0;
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        req_valid = '1;
        mem_ack   = 1'b0;
        #1 checkOutput("rst_ready", 32'(req_ready), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst      = 1'b0;
        req_valid  = '0;
        model_last = N - 1;
        exp_rsp    = '0;
        exp_err    = 1'b0;
        exp_rdata  = '0;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    endtask

    task automatic reset_in_busy(input logic [N-1:0] v);
        int win;
        check_rsp();
        req_we    = t_we;
        req_addr  = t_addr;
        req_wdata = t_wdata;
        req_valid = v;
        win = model_pick(v);
        #1 checkOutput("rb_ready", 32'(req_ready), 32'(1) << win);
        @(negedge i_clk);
        req_valid = '0;
        #1 checkOutput("rb_mem_req0", 32'(mem_req), 32'd1);
        @(negedge i_clk);
        checkOutput("rb_mem_req1", 32'(mem_req), 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst      = 1'b0;
        model_last = N - 1;
        checkOutput("rb_mem_req_off", 32'(mem_req), 32'd0);
        checkOutput("rb_rsp0", 32'(rsp_valid), 32'd0);
        @(negedge i_clk);
        checkOutput("rb_rsp1", 32'(rsp_valid), 32'd0);
        checkOutput("rb_err", 32'(rsp_err), 32'd0);
        checkOutput("rb_mem_req2", 32'(mem_req), 32'd0);
    endtask

    initial begin
`ifdef AUDIO_ARB_RR_EN
        order_exp = '{0, 1, 2, 3, 0};
`else
        order_exp = '{0, 0, 0, 0, 0};
`endif
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        i_rst     = 1'b1;
        @(negedge i_clk);
        do_reset();
        idle_cycle(1'b0);

        // Single read from the play engine, acked 3 cycles into BUSY.
        rand_fields();
        t_we[1]   = 1'b0;
        t_addr[1] = 23'h000100;
        t_rdata   = 16'hBEEF;
        applyStimulus(4'b0010, 3, w);
        idle_cycle(1'b0);

        // All requesters contending, back-to-back from a fresh reset.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            applyStimulus(4'b1111, 0, w);
            checkOutput("order", 32'(ready_seen), 32'(1) << order_exp[i]);
        end
        idle_cycle(1'b0);

        // Write held stable across several BUSY cycles.
        rand_fields();
        t_we[0]    = 1'b1;
        t_wdata[0] = 16'h1234;
        t_addr[0]  = 23'h040000;
        applyStimulus(4'b0001, 4, w);

        // Watchdog abort, then an immediate follow-on request.
        rand_fields();
        applyStimulus(4'b0100, 100, w);
        rand_fields();
        t_we[3] = 1'b0;
        applyStimulus(4'b1000, 2, w);

        // Ack on the final watchdog cycle must win.
        rand_fields();
        t_we[2] = 1'b0;
        applyStimulus(4'b0100, TO - 1, w);

        // Stray acks while idle are ignored.
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Reset mid-transaction, then a clean transaction.
        rand_fields();
        reset_in_busy(4'b0110);
        rand_fields();
        applyStimulus(4'b1010, 1, w);

        for (int n = 0; n < 40; n++) begin
            rand_fields();
            applyStimulus(N'($urandom_range(1, 15)), $urandom_range(0, 10), w);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);
        idle_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
